// File: rtl/decode.sv
// ID stage of the MIPS-subset pipeline: register file with write-before-read
// bypass, main control decode, sign extension and the ID/EX pipeline register.
module decode #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       if_id_instr,
  input  logic [WIDTH-1:0]  if_id_npc,
  input  logic              id_flush,
  input  logic              mem_wb_reg_write,
  input  logic [REG_AW-1:0] mem_wb_write_reg,
  input  logic [WIDTH-1:0]  wb_write_data,
  output logic [1:0]        id_ex_wb,
  output logic [2:0]        id_ex_m,
  output logic [3:0]        id_ex_ex,
  output logic [WIDTH-1:0]  id_ex_npc,
  output logic [WIDTH-1:0]  id_ex_readdat1,
  output logic [WIDTH-1:0]  id_ex_readdat2,
  output logic [WIDTH-1:0]  id_ex_sign_ext,
  output logic [4:0]        id_ex_instr_2016,
  output logic [4:0]        id_ex_instr_1511
);

  localparam int NREGS = 1 << REG_AW;

  logic [WIDTH-1:0]  regs_r [NREGS];
  logic [5:0]        opcode_s;
  logic [REG_AW-1:0] rs_s;
  logic [REG_AW-1:0] rt_s;
  logic [4:0]        rd_s;
  logic              wb_we_s;
  logic [WIDTH-1:0]  readdat1_s;
  logic [WIDTH-1:0]  readdat2_s;
  logic [WIDTH-1:0]  sign_ext_s;
  logic [1:0]        wb_ctl_s;
  logic [2:0]        m_ctl_s;
  logic [3:0]        ex_ctl_s;

  assign opcode_s   = if_id_instr[31:26];
  assign rs_s       = if_id_instr[25:21];
  assign rt_s       = if_id_instr[20:16];
  assign rd_s       = if_id_instr[15:11];
  assign sign_ext_s = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
  // $0 is never a write target, so a write to it can neither land nor bypass
  assign wb_we_s    = mem_wb_reg_write && (mem_wb_write_reg != {REG_AW{1'b0}});

  // Register read with same-cycle write-back forwarding; $0 reads as zero
  always_comb begin
    readdat1_s = {WIDTH{1'b0}};
    readdat2_s = {WIDTH{1'b0}};
    if (rs_s == {REG_AW{1'b0}}) begin
      readdat1_s = {WIDTH{1'b0}};
    end else if (wb_we_s && (mem_wb_write_reg == rs_s)) begin
      readdat1_s = wb_write_data;
    end else begin
      readdat1_s = regs_r[rs_s];
    end
    if (rt_s == {REG_AW{1'b0}}) begin
      readdat2_s = {WIDTH{1'b0}};
    end else if (wb_we_s && (mem_wb_write_reg == rt_s)) begin
      readdat2_s = wb_write_data;
    end else begin
      readdat2_s = regs_r[rt_s];
    end
  end

  // Main control: unsupported opcodes decode to a NOP
  always_comb begin
    wb_ctl_s = 2'b00;
    m_ctl_s  = 3'b000;
    ex_ctl_s = 4'b0000;
    case (opcode_s)
      6'h00: begin wb_ctl_s = 2'b10; m_ctl_s = 3'b000; ex_ctl_s = 4'b1100; end
      6'h23: begin wb_ctl_s = 2'b11; m_ctl_s = 3'b010; ex_ctl_s = 4'b0001; end
      6'h2B: begin wb_ctl_s = 2'b00; m_ctl_s = 3'b001; ex_ctl_s = 4'b0001; end
      6'h04: begin wb_ctl_s = 2'b00; m_ctl_s = 3'b100; ex_ctl_s = 4'b0010; end
      default: begin wb_ctl_s = 2'b00; m_ctl_s = 3'b000; ex_ctl_s = 4'b0000; end
    endcase
  end

  // Register file storage
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wb_we_s) begin
      regs_r[mem_wb_write_reg] <= wb_write_data;
    end
  end

  // ID/EX pipeline register; flush squashes only the control bundles
  always_ff @(posedge clk) begin
    if (!rst) begin
      id_ex_wb         <= 2'b00;
      id_ex_m          <= 3'b000;
      id_ex_ex         <= 4'b0000;
      id_ex_npc        <= {WIDTH{1'b0}};
      id_ex_readdat1   <= {WIDTH{1'b0}};
      id_ex_readdat2   <= {WIDTH{1'b0}};
      id_ex_sign_ext   <= {WIDTH{1'b0}};
      id_ex_instr_2016 <= 5'd0;
      id_ex_instr_1511 <= 5'd0;
    end else begin
      if (id_flush) begin
        id_ex_wb <= 2'b00;
        id_ex_m  <= 3'b000;
        id_ex_ex <= 4'b0000;
      end else begin
        id_ex_wb <= wb_ctl_s;
        id_ex_m  <= m_ctl_s;
        id_ex_ex <= ex_ctl_s;
      end
      id_ex_npc        <= if_id_npc;
      id_ex_readdat1   <= readdat1_s;
      id_ex_readdat2   <= readdat2_s;
      id_ex_sign_ext   <= sign_ext_s;
      id_ex_instr_2016 <= if_id_instr[20:16];
      id_ex_instr_1511 <= rd_s;
    end
  end

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for the decode stage: a reference register-file/control
// model predicts each ID/EX result when the stimulus is driven.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic        id_flush;
  logic        mem_wb_reg_write;
  logic [4:0]  mem_wb_write_reg;
  logic [31:0] wb_write_data;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_m;
  logic [3:0]  id_ex_ex;
  logic [31:0] id_ex_npc, id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext;
  logic [4:0]  id_ex_instr_2016, id_ex_instr_1511;

  always #5 clk = ~clk;

  decode dut (
    .clk(clk), .rst(rst), .if_id_instr(if_id_instr), .if_id_npc(if_id_npc),
    .id_flush(id_flush), .mem_wb_reg_write(mem_wb_reg_write),
    .mem_wb_write_reg(mem_wb_write_reg), .wb_write_data(wb_write_data),
    .id_ex_wb(id_ex_wb), .id_ex_m(id_ex_m), .id_ex_ex(id_ex_ex),
    .id_ex_npc(id_ex_npc), .id_ex_readdat1(id_ex_readdat1),
    .id_ex_readdat2(id_ex_readdat2), .id_ex_sign_ext(id_ex_sign_ext),
    .id_ex_instr_2016(id_ex_instr_2016), .id_ex_instr_1511(id_ex_instr_1511)
  );

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] npc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] sext;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_regs [32];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Drive one cycle of stimulus, predict its ID/EX result and compare it.
  task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] npc,
                      input logic fl, input logic we, input logic [4:0] wr,
                      input logic [31:0] wd);
    exp_t       e;
    logic [5:0] op;
    logic [4:0] rs, rt;
    @(negedge clk);
    rst = r; if_id_instr = ins; if_id_npc = npc; id_flush = fl;
    mem_wb_reg_write = we; mem_wb_write_reg = wr; wb_write_data = wd;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
    e = '0;
    if (r) begin
      case (op)
        6'h00: {e.wb, e.m, e.ex} = 9'b10_000_1100;
        6'h23: {e.wb, e.m, e.ex} = 9'b11_010_0001;
        6'h2B: {e.wb, e.m, e.ex} = 9'b00_001_0001;
        6'h04: {e.wb, e.m, e.ex} = 9'b00_100_0010;
        default: {e.wb, e.m, e.ex} = 9'b0;
      endcase
      if (fl) {e.wb, e.m, e.ex} = 9'b0;
      e.npc  = npc;
      e.rd1  = (rs == 5'd0) ? 32'd0 : ((we && wr == rs) ? wd : model_regs[rs]);
      e.rd2  = (rt == 5'd0) ? 32'd0 : ((we && wr == rt) ? wd : model_regs[rt]);
      e.sext = {{16{ins[15]}}, ins[15:0]};
      e.rt   = rt;
      e.rd   = ins[15:11];
    end
    sb_q.push_back(e);
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    end else if (we && wr != 5'd0) begin
      model_regs[wr] = wd;
    end
    #1;
    e = sb_q.pop_front();
    check_val("wb",       {30'd0, id_ex_wb},         {30'd0, e.wb});
    check_val("m",        {29'd0, id_ex_m},          {29'd0, e.m});
    check_val("ex",       {28'd0, id_ex_ex},         {28'd0, e.ex});
    check_val("npc",      id_ex_npc,                 e.npc);
    check_val("readdat1", id_ex_readdat1,            e.rd1);
    check_val("readdat2", id_ex_readdat2,            e.rd2);
    check_val("sign_ext", id_ex_sign_ext,            e.sext);
    check_val("rt",       {27'd0, id_ex_instr_2016}, {27'd0, e.rt});
    check_val("rd",       {27'd0, id_ex_instr_1511}, {27'd0, e.rd});
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [31:0] ins;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B;
    ops[3] = 6'h04; ops[4] = 6'h3C; ops[5] = 6'h08;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    rst = 1'b0; if_id_instr = 32'd0; if_id_npc = 32'd0; id_flush = 1'b0;
    mem_wb_reg_write = 1'b0; mem_wb_write_reg = 5'd0; wb_write_data = 32'd0;

    // Reset, including a write-back that reset must override
    step(1'b0, 32'h8C88FFFC, 32'h4, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b0, 32'h8C88FFFC, 32'h4, 1'b1, 1'b1, 5'd4, 32'hAAAA5555);
    check_val("reset_sext", id_ex_sign_ext, 32'd0);
    step(1'b1, 32'h00852020, 32'h8, 1'b0, 1'b0, 5'd0, 32'd0);
    check_val("post_reset_rd1", id_ex_readdat1, 32'd0);

    // Write then read
    step(1'b1, 32'h00000000, 32'h10, 1'b0, 1'b1, 5'd8, 32'hDEADBEEF);
    step(1'b1, 32'h01095020, 32'h14, 1'b0, 1'b0, 5'd0, 32'd0);
    check_val("wr_rd1", id_ex_readdat1, 32'hDEADBEEF);
    check_val("wr_rd", {27'd0, id_ex_instr_1511}, 32'd10);

    // Bypass on rt, then persistence, then dual bypass
    step(1'b1, 32'h01095020, 32'h18, 1'b0, 1'b1, 5'd9, 32'h12345678);
    check_val("byp_rd2", id_ex_readdat2, 32'h12345678);
    step(1'b1, 32'h01095020, 32'h1C, 1'b0, 1'b0, 5'd0, 32'd0);
    check_val("keep_rd2", id_ex_readdat2, 32'h12345678);
    step(1'b1, 32'h01084020, 32'h20, 1'b0, 1'b1, 5'd8, 32'hCAFEF00D);

    // $0 protection, stored and bypassed
    step(1'b1, 32'h00000000, 32'h24, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
    step(1'b1, 32'h00004020, 32'h28, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
    check_val("zero_rd1", id_ex_readdat1, 32'd0);

    // lw / sw / beq / flush / unsupported opcode
    step(1'b1, 32'h8C88FFFC, 32'h2C, 1'b0, 1'b0, 5'd0, 32'd0);
    check_val("lw_sext", id_ex_sign_ext, 32'hFFFFFFFC);
    step(1'b1, 32'hAC880004, 32'h30, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 32'h1109FFFE, 32'h34, 1'b0, 1'b0, 5'd0, 32'd0);
    check_val("beq_m", {29'd0, id_ex_m}, 32'h4);
    step(1'b1, 32'h1109FFFE, 32'h38, 1'b1, 1'b0, 5'd0, 32'd0);
    check_val("flush_sext", id_ex_sign_ext, 32'hFFFFFFFE);
    step(1'b1, 32'h3C01FFFF, 32'h3C, 1'b0, 1'b0, 5'd0, 32'd0);

    // Random mix of instructions, write-backs and flushes
    for (int k = 0; k < 60; k++) begin
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 5)];
      step(1'b1, ins, $urandom, ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom);
    end

    // Mid-stream reset clears the register file
    step(1'b0, 32'h01095020, 32'h40, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 32'h01095020, 32'h44, 1'b0, 1'b0, 5'd0, 32'd0);
    check_val("mid_reset_rd1", id_ex_readdat1, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- Instruction Decode (ID) stage of the 5-stage MIPS-subset pipeline; sits directly downstream of fetch.
- Consumes the IF/ID pair: the fetched instruction and its PC+4.
- Holds the 32x32 register file, which the MEM/WB stage writes back into, plus the main control unit and the 16→32 sign extender.
- Registers everything into the ID/EX pipeline register for the execute stage.

Parameters:
- WIDTH, 32, datapath/register width (only 32 supported).
- REG_AW, 5, register address width (32 registers).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low (0 = reset, sampled on posedge clk).
- if_id_instr  in  32  instruction from fetch.
- if_id_npc  in  32  PC+4 from fetch.
- id_flush  in  1  squash: load zero controls into ID/EX this cycle.
- mem_wb_reg_write  in  1  write-back enable.
- mem_wb_write_reg  in  5  write-back destination register.
- wb_write_data  in  32  write-back data.
- id_ex_wb  out  2  {RegWrite, MemtoReg}.
- id_ex_m  out  3  {Branch, MemRead, MemWrite}.
- id_ex_ex  out  4  {RegDst, ALUOp[1:0], ALUSrc}.
- id_ex_npc  out  32  registered if_id_npc.
- id_ex_readdat1  out  32  rs value.
- id_ex_readdat2  out  32  rt value.
- id_ex_sign_ext  out  32  sign-extended instr[15:0].
- id_ex_instr_2016  out  5  rt field.
- id_ex_instr_1511  out  5  rd field.

Behaviour:
- Reset: when rst==0 at posedge clk, all 32 registers and all id_ex_* outputs are cleared to 0. Reset overrides write-back and flush. Reset mid-stream discards the in-flight instruction.
- Latency: 1 cycle. The ID/EX outputs at posedge N+1 reflect the inputs present during cycle N. No stall input; the stage captures every cycle.
- Field decode:
  - opcode = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11].
  - sign_ext = {{16{instr[15]}}, instr[15:0]}.
- Control (combinational from opcode, then registered), listed as wb / m / ex:
  - R-type 0x00: 10 / 000 / 1100.
  - lw 0x23: 11 / 010 / 0001.
  - sw 0x2B: 00 / 001 / 0001.
  - beq 0x04: 00 / 100 / 0010.
  - Any other opcode: all zero (behaves as a NOP).
- Flush: with id_flush=1, id_ex_wb, id_ex_m and id_ex_ex load 0. Data fields (npc, readdat, sign_ext, reg fields) still load normally.
- Register file write: on posedge clk when rst=1, mem_wb_reg_write=1 and mem_wb_write_reg!=0, write reg[mem_wb_write_reg] <= wb_write_data.
- Register $0: writes to $0 are ignored; reads of $0 always return 0.
- Register file read: combinational on rs and rt, with write-before-read bypass. If a same-cycle write targets a non-zero register equal to rs (or rt), that readdat captures wb_write_data rather than the stale array value. rs and rt may both bypass at once.
- Register fields pass through unmodified: id_ex_instr_2016 = rt, id_ex_instr_1511 = rd.

Test Plan:
- Reset: hold rst=0 for 2 cycles with instr=0x8C88FFFC → every id_ex_* output = 0. After release, decoding 0x00852020 (add $4,$4,$5) gives readdat1 = readdat2 = 0.
- Write then read: write $8=0xDEADBEEF via WB, then decode 0x01095020 (add $10,$8,$9) with npc=0x00000014 → next posedge: readdat1=0xDEADBEEF, readdat2=0, wb=10, m=000, ex=1100, instr_1511=10, instr_2016=9, npc=0x00000014.
- Bypass: in the same cycle, write $9=0x12345678 and decode 0x01095020 → readdat2=0x12345678 at the next posedge, and $9 keeps that value afterwards.
- $0 protection: write $0=0xFFFFFFFF, then decode 0x00004020 (add $8,$0,$0) → readdat1 = readdat2 = 0. A same-cycle write to $0 is not bypassed.
- lw decode: 0x8C88FFFC → sign_ext=0xFFFFFFFC, wb=11, m=010, ex=0001, instr_2016=8. Then sw 0xAC880004 → sign_ext=0x00000004, wb=00, m=001, ex=0001.
- beq with flush: decode 0x1109FFFE (beq) → m=100, ex=0010. Same instruction with id_flush=1 → wb, m, ex = 0 while sign_ext=0xFFFFFFFE still loads. Opcode 0x3C (lui, unsupported) → all controls 0.
